sram_2k_arbiter: RTL and testbench

//  Shares one single-port synchronous 2K x 8 RAM (the block-RAM behind the 6116 SRAM bridge)

---
 rtl/sram_2k_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_2k_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2k_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two req/ack ports.
// One access in flight; every output is a register.
`timescale 1ns/1ps
module sram_2k_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  output logic              mem_en,
  output logic              busy,
  output logic              gnt_id,
  output logic [CNT_W-1:0]  contention
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LAT_INIT = 3'(RD_LAT - 1);

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       any_req_s;
  logic       both_req_s;
  logic       gnt_s;

  // Pick the port to grant: a lone requester wins, a contest goes to the non-last owner.
  always_comb begin
    any_req_s  = req0 | req1;
    both_req_s = req0 & req1;
    if (both_req_s) begin
      gnt_s = ~gnt_id;
    end else if (req1) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Access sequencer: grant, drive RAM for one cycle, wait out read latency, ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= {DATA_W{1'b0}};
      rdata1     <= {DATA_W{1'b0}};
      mem_addr   <= {ADDR_W{1'b0}};
      mem_din    <= {DATA_W{1'b0}};
      mem_we     <= 1'b0;
      mem_en     <= 1'b0;
      busy       <= 1'b0;
      gnt_id     <= 1'b1;
      contention <= {CNT_W{1'b0}};
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r  <= ACCESS;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            gnt_id   <= gnt_s;
            mem_addr <= gnt_s ? addr1 : addr0;
            mem_din  <= gnt_s ? wdata1 : wdata0;
            mem_we   <= gnt_s ? we1 : we0;
            if (both_req_s && (contention != CNT_MAX)) begin
              contention <= contention + CNT_ONE;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // mem_we still reflects the granted operation during this cycle
          if (mem_we) begin
            state_r <= DONE;
            ack0    <= ~gnt_id;
            ack1    <= gnt_id;
          end else begin
            state_r <= WAIT;
            cnt_r   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (cnt_r == 3'd0) begin
            if (gnt_id) begin
              rdata1 <= mem_dout;
            end else begin
              rdata0 <= mem_dout;
            end
            state_r <= DONE;
            ack0    <= ~gnt_id;
            ack1    <= gnt_id;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_2k_arbiter.sv
// Self-checking bench for sram_2k_arbiter: scoreboarded main instance, read-latency sweep
// instances (RD_LAT 1..4) and a 4-bit contention-counter instance under permanent contest.
`timescale 1ns/1ps
module tb_sram_2k_arbiter;

  localparam int RD_LAT = 1;
  localparam int M      = 6;

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we, mem_en, busy, gnt_id;
  logic [15:0] contention;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] shadow [0:2047];
  logic [7:0] last0, last1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
    $fatal(1);
  end

  sram_2k_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LAT(RD_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_en(mem_en), .busy(busy), .gnt_id(gnt_id),
    .contention(contention)
  );

  // Single-port RAM model with one clock of read latency.
  logic [7:0] ram [0:2047];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_dout = ram_q;

  // Latency-sweep instances, port 1 idle.
  logic        lat_req   [4];
  logic        lat_ack   [4];
  logic        lat_en    [4];
  logic [7:0]  lat_rdata [4];
  logic [7:0]  lat_dout  [4];
  logic [10:0] lat_addr;
  logic        lat_we;
  logic [7:0]  lat_wdata;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [10:0] maddr;
    logic [7:0]  mdin;
    logic        mwe, ack1_u, busy_u, gnt_u;
    logic [7:0]  rd1_u;
    logic [15:0] cont_u;
    logic [7:0]  mem  [0:2047];
    logic [7:0]  pipe [0:g];

    sram_2k_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LAT(g + 1), .CNT_W(16)) u_lat (
      .clk(clk), .rst(rst),
      .req0(lat_req[g]), .req1(1'b0), .addr0(lat_addr), .addr1(11'h000),
      .we0(lat_we), .we1(1'b0), .wdata0(lat_wdata), .wdata1(8'h00),
      .ack0(lat_ack[g]), .ack1(ack1_u), .rdata0(lat_rdata[g]), .rdata1(rd1_u),
      .mem_addr(maddr), .mem_din(mdin), .mem_dout(lat_dout[g]),
      .mem_we(mwe), .mem_en(lat_en[g]), .busy(busy_u), .gnt_id(gnt_u),
      .contention(cont_u)
    );

    always @(posedge clk) begin
      if (lat_en[g] && mwe)  mem[maddr] <= mdin;
      if (lat_en[g] && !mwe) pipe[0] <= mem[maddr];
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end
    assign lat_dout[g] = pipe[g];
  end

  // Saturation instance: both ports request reads forever.
  logic        sat_rst;
  logic        sat_ack0, sat_ack1, sat_we, sat_en, sat_busy, sat_gnt;
  logic [7:0]  sat_rd0, sat_rd1, sat_din;
  logic [10:0] sat_addr;
  logic [3:0]  sat_cont;
  int          sat_acks;

  sram_2k_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(sat_rst),
    .req0(1'b1), .req1(1'b1), .addr0(11'h001), .addr1(11'h002),
    .we0(1'b0), .we1(1'b0), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(sat_ack0), .ack1(sat_ack1), .rdata0(sat_rd0), .rdata1(sat_rd1),
    .mem_addr(sat_addr), .mem_din(sat_din), .mem_dout(8'h00),
    .mem_we(sat_we), .mem_en(sat_en), .busy(sat_busy), .gnt_id(sat_gnt),
    .contention(sat_cont)
  );

  initial begin
    sat_acks = 0;
    forever begin
      @(negedge clk);
      if (sat_rst) sat_acks = 0;
      else if (sat_ack0 || sat_ack1) sat_acks = sat_acks + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack pops the entry pushed when the request was driven.
  initial begin
    exp_t e;
    last0 = 8'h00;
    last1 = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        last0 = 8'h00;
        last1 = 8'h00;
      end else begin
        if (ack0) begin
          if (q0.size() == 0) check_eq("ack0_unexpected", 32'd1, 32'd0);
          else begin
            e = q0.pop_front();
            if (e.we) check_eq("rdata0_hold_on_write", {24'd0, rdata0}, {24'd0, last0});
            else begin
              check_eq("rdata0", {24'd0, rdata0}, {24'd0, e.data});
              last0 = e.data;
            end
          end
        end
        if (ack1) begin
          if (q1.size() == 0) check_eq("ack1_unexpected", 32'd1, 32'd0);
          else begin
            e = q1.pop_front();
            if (e.we) check_eq("rdata1_hold_on_write", {24'd0, rdata1}, {24'd0, last1});
            else begin
              check_eq("rdata1", {24'd0, rdata1}, {24'd0, e.data});
              last1 = e.data;
            end
          end
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check_eq({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check_eq({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check_eq({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_gnt_id"}, {31'd0, gnt_id}, 32'd1);
    check_eq({tag, "_rdata0"}, {24'd0, rdata0}, 32'd0);
    check_eq({tag, "_rdata1"}, {24'd0, rdata1}, 32'd0);
    check_eq({tag, "_mem_addr"}, {21'd0, mem_addr}, 32'd0);
    check_eq({tag, "_mem_din"}, {24'd0, mem_din}, 32'd0);
    check_eq({tag, "_contention"}, {16'd0, contention}, 32'd0);
  endtask

  // Uncontested access on the main instance; checks latency and the single enable pulse.
  task automatic do_access(input int p, input logic [10:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    int   n, en_n;
    logic got;
    @(negedge clk);
    e.we   = w;
    e.data = w ? d : shadow[a];
    if (w) shadow[a] = d;
    if (p == 0) begin
      addr0 = a; we0 = w; wdata0 = d; req0 = 1'b1; q0.push_back(e);
    end else begin
      addr1 = a; we1 = w; wdata1 = d; req1 = 1'b1; q1.push_back(e);
    end
    n = 0; en_n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n = n + 1;
      if (n == 1) check_eq("busy_in_access", {31'd0, busy}, 32'd1);
      if (mem_en) begin
        en_n = en_n + 1;
        check_eq("mem_addr", {21'd0, mem_addr}, {21'd0, a});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, w});
        if (w) check_eq("mem_din", {24'd0, mem_din}, {24'd0, d});
      end else begin
        check_eq("mem_we_outside_access", {31'd0, mem_we}, 32'd0);
      end
      got = (p == 0) ? ack0 : ack1;
    end
    check_eq("ack_seen", {31'd0, got}, 32'd1);
    check_eq("latency", n, w ? 32'd2 : 32'(2 + RD_LAT));
    check_eq("en_cycles", en_n, 32'd1);
    check_eq("gnt_id_at_ack", {31'd0, gnt_id}, p);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic lat_access(input int g, input logic [10:0] a, input logic w, input logic [7:0] d);
    int   n, en_n;
    logic got;
    @(negedge clk);
    lat_addr = a; lat_we = w; lat_wdata = d; lat_req[g] = 1'b1;
    n = 0; en_n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n = n + 1;
      if (lat_en[g]) en_n = en_n + 1;
      got = lat_ack[g];
    end
    check_eq("lat_ack_seen", {31'd0, got}, 32'd1);
    check_eq("lat_latency", n, w ? 32'd2 : 32'(3 + g));
    check_eq("lat_en_cycles", en_n, 32'd1);
    if (!w) check_eq("lat_rdata", {24'd0, lat_rdata[g]}, {24'd0, d});
    lat_req[g] = 1'b0;
  endtask

  task automatic issue(input int p, input int i);
    exp_t        e;
    logic [10:0] a;
    logic [7:0]  d;
    a = ((p == 0) ? 11'h100 : 11'h200) + 11'(i);
    d = 8'h30 + 8'(i) + ((p == 0) ? 8'h00 : 8'h80);
    e.we = 1'b1;
    e.data = d;
    shadow[a] = d;
    if (p == 0) begin
      addr0 = a; we0 = 1'b1; wdata0 = d; req0 = 1'b1; q0.push_back(e);
    end else begin
      addr1 = a; we1 = 1'b1; wdata1 = d; req1 = 1'b1; q1.push_back(e);
    end
  endtask

  initial begin
    int seen, acks, d0, d1, guard, exp_cont;
    rst = 1'b1; sat_rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 11'h000; addr1 = 11'h000; wdata0 = 8'h00; wdata1 = 8'h00;
    lat_addr = 11'h000; lat_we = 1'b0; lat_wdata = 8'h00;
    for (int i = 0; i < 4; i++) lat_req[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0; sat_rst = 1'b0;

    // T1: reset while a read sits in WAIT
    @(negedge clk);
    addr0 = 11'h010; we0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t1_busy_in_wait", {31'd0, busy}, 32'd1);
    check_eq("t1_en_in_wait", {31'd0, mem_en}, 32'd0);
    rst = 1'b1; req0 = 1'b0; seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) seen = seen + 1;
    end
    check_reset("t1_in_reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) seen = seen + 1;
    end
    check_eq("t1_no_ack", seen, 32'd0);
    check_reset("t1_after");

    // T2: top-address write then read-back on both ports
    do_access(0, 11'h7FF, 1'b1, 8'hA5);
    do_access(0, 11'h7FF, 1'b0, 8'h00);
    do_access(1, 11'h7FF, 1'b0, 8'h00);

    // T3: both ports held high from reset
    @(negedge clk);
    rst = 1'b1;
    q0.delete(); q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0);
    issue(1, 0);
    acks = 0; d0 = 0; d1 = 0; guard = 0;
    while (acks < 2 * M && guard < 400) begin
      @(negedge clk);
      guard = guard + 1;
      if (ack0 || ack1) begin
        acks = acks + 1;
        exp_cont = (acks <= 2 * M - 1) ? acks : 2 * M - 1;
        check_eq("t3_gnt_order", {31'd0, ack1}, (acks - 1) % 2);
        check_eq("t3_gnt_id", {31'd0, gnt_id}, (acks - 1) % 2);
        check_eq("t3_contention", {16'd0, contention}, exp_cont);
        if (ack0) begin
          d0 = d0 + 1;
          if (d0 < M) issue(0, d0);
          else req0 = 1'b0;
        end
        if (ack1) begin
          d1 = d1 + 1;
          if (d1 < M) issue(1, d1);
          else req1 = 1'b0;
        end
      end
    end
    check_eq("t3_ack_count", acks, 2 * M);
    do_access(0, 11'h102, 1'b0, 8'h00);
    do_access(1, 11'h205, 1'b0, 8'h00);
    do_access(0, 11'h205, 1'b0, 8'h00);

    // T4: read-latency sweep
    for (int g = 0; g < 4; g++) begin
      lat_access(g, 11'h123, 1'b1, 8'h3C);
      lat_access(g, 11'h123, 1'b0, 8'h3C);
    end

    // T5: cross-port isolation
    do_access(1, 11'h055, 1'b1, 8'h11);
    do_access(0, 11'h7FF, 1'b0, 8'h00);
    do_access(0, 11'h055, 1'b1, 8'h22);
    do_access(1, 11'h055, 1'b0, 8'h00);
    @(negedge clk);
    check_eq("t5_rdata0_kept", {24'd0, rdata0}, 32'h0000_00A5);
    check_eq("t5_rdata1", {24'd0, rdata1}, 32'h0000_0022);
    check_eq("idle_mem_addr_hold", {21'd0, mem_addr}, 32'h0000_0055);
    check_eq("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // T6: 4-bit contention counter saturates
    repeat (20) @(negedge clk);
    check_eq("t6_enough_grants", {31'd0, sat_acks >= 20}, 32'd1);
    check_eq("t6_contention_sat", {28'd0, sat_cont}, 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
